seg_execute_muldiv_ctrl: RTL and testbench
==========================================

Name: seg_execute_muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer sitting beside the EX-stage ALU.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and owns the HI/LO architectural registers.
- Drives a stall to the hazard/pipeline-register logic, so the issuing instruction is held in EX until the result commits.
- Operands arrive already forwarded (the post-forwarding-mux A/B values).

Parameters:
- LEN, 32, datapath and HI/LO width.
- NB_CNT, 6, iteration counter width; must satisfy 2^NB_CNT > LEN.
- NB_OP, 2, width of the operation select.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_rst  in  1  reset; asynchronous, active-low.
- i_start  in  1  EX stage holds a mul/div instruction.
- i_op  in  NB_OP  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- i_data_a  in  LEN  rs operand (multiplicand / dividend), post-forwarding.
- i_data_b  in  LEN  rt operand (multiplier / divisor), post-forwarding.
- i_mthi  in  1  write i_data_a into HI.
- i_mtlo  in  1  write i_data_a into LO.
- i_flush  in  1  abort the in-flight operation (branch/exception squash).
- o_stall  out  1  freeze PC, IF/ID and ID/EX; insert bubble into EX/MEM.
- o_busy  out  1  FSM not IDLE and not COMMIT.
- o_done  out  1  one-cycle pulse when HI/LO take a new result.
- o_hi  out  LEN  HI register (read by MFHI).
- o_lo  out  LEN  LO register (read by MFLO).

Behaviour:
- FSM states: IDLE, RUN, FIX, COMMIT.
- Reset (async, i_rst=0): state IDLE; counter=0; HI=LO=0; o_stall, o_busy and o_done all 0. Takes effect mid-operation, with no partial commit.
- IDLE:
  - o_stall = i_start (combinational), so the issuing cycle already stalls.
  - On i_start: capture |a|, |b| for signed ops (raw values for unsigned ops), plus the sign flags and op.
  - Clear the accumulator and remainder, load counter = LEN, go to RUN.
- RUN:
  - One radix-2 step per cycle.
  - Multiply: shift-add into a 2*LEN accumulator.
  - Divide: restoring shift-subtract, quotient in the low half and remainder in the high half.
  - Counter decrements; when it reaches 1, go to FIX. RUN lasts exactly LEN cycles.
- FIX:
  - Sign correction, one cycle.
  - Signed multiply: negate the 2*LEN product if sign_a^sign_b.
  - Signed divide: negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
  - Go to COMMIT.
- COMMIT:
  - HI/LO were written on entry: multiply gives HI=product[2*LEN-1:LEN] and LO=product[LEN-1:0]; divide gives HI=remainder and LO=quotient.
  - o_done=1 and o_stall=0, so the pipeline advances.
  - i_start is ignored in this cycle, because it is still the same instruction.
  - Always go to IDLE next.
- Latency: start accepted in cycle 0. o_stall is high in cycles 0..LEN+1 (34 cycles at default). COMMIT is cycle LEN+2, and o_hi/o_lo are valid from that cycle.
- o_busy is high in RUN and FIX only.
- Division by zero: no trap. LO = all ones, HI = the original dividend i_data_a (unsigned value captured); full latency still applies.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0. This falls out naturally from the magnitude arithmetic.
- i_mthi/i_mtlo:
  - Honoured only in IDLE with i_start=0; HI/LO update on the next edge.
  - Ignored in every other state and when i_start=1 (start has priority).
  - i_mthi and i_mtlo together are legal and write both registers.
- i_flush:
  - In RUN or FIX: go to IDLE next cycle, HI/LO unchanged, o_done stays 0.
  - In IDLE: also blocks acceptance of i_start that cycle.
  - In COMMIT: no effect, since the result has already been written.
- Results are deterministic; no X propagation from uncaptured inputs while busy (inputs sampled only in IDLE).

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> o_stall high for 34 cycles; COMMIT: HI=0xFFFFFFFE, LO=0x00000001, o_done single pulse.
- MULT -7 × 3 (0xFFFFFFF9, 0x00000003) -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV -7 / 2 -> LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1); DIVU 100 / 7 -> LO=14, HI=2.
- DIV 5 / 0 -> LO=0xFFFFFFFF, HI=5; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Flush at RUN cycle 10 of a MULT with HI/LO preloaded via MTHI=0x1234/MTLO=0x5678 -> IDLE next cycle, HI/LO still 0x1234/0x5678, no o_done.
- Reset asserted asynchronously mid-DIVU -> outputs 0 immediately, state IDLE. Then i_start held high through COMMIT -> exactly one operation executes and one o_done pulse occurs.

Source files
------------

// File: rtl/seg_execute_muldiv_ctrl_if.sv
// EX-stage mul/div sequencer bus: issue, operands, HI/LO moves,
// squash, and the stall/result signals returned to the pipeline.
interface seg_execute_muldiv_ctrl_if #(
    parameter int LEN   = 32,
    parameter int NB_OP = 2
);
    logic             i_start;
    logic [NB_OP-1:0] i_op;
    logic [LEN-1:0]   i_data_a;
    logic [LEN-1:0]   i_data_b;
    logic             i_mthi;
    logic             i_mtlo;
    logic             i_flush;
    logic             o_stall;
    logic             o_busy;
    logic             o_done;
    logic [LEN-1:0]   o_hi;
    logic [LEN-1:0]   o_lo;

    modport master (
        output i_start, i_op, i_data_a, i_data_b,
        output i_mthi, i_mtlo, i_flush,
        input  o_stall, o_busy, o_done, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_data_a, i_data_b,
        input  i_mthi, i_mtlo, i_flush,
        output o_stall, o_busy, o_done, o_hi, o_lo
    );
endinterface

// File: rtl/seg_execute_muldiv_ctrl.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Works on magnitudes, then fixes signs in one extra cycle.
module seg_execute_muldiv_ctrl #(
    parameter int LEN    = 32,
    parameter int NB_CNT = 6,
    parameter int NB_OP  = 2
) (
    input logic i_clk,
    input logic i_rst,
    seg_execute_muldiv_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        COMMIT
    } state_t;

    state_t              state;
    logic [NB_CNT-1:0]   cnt;
    logic [2*LEN-1:0]    acc;
    logic [LEN-1:0]      opa;
    logic [LEN-1:0]      opb;
    logic [LEN-1:0]      hi;
    logic [LEN-1:0]      lo;
    logic                sign_a;
    logic                sign_b;
    logic                is_div;
    logic                is_sgn;
    logic                b_zero;

    logic                in_sgn;
    logic                in_neg_a;
    logic                in_neg_b;
    logic [LEN-1:0]      abs_a;
    logic [LEN-1:0]      abs_b;
    logic [LEN:0]        mul_sum;
    logic [2*LEN-1:0]    mul_nxt;
    logic [LEN:0]        div_sh;
    logic [LEN:0]        div_diff;
    logic [2*LEN-1:0]    div_nxt;
    logic [2*LEN-1:0]    prod_fix;
    logic [LEN-1:0]      q_fix;
    logic [LEN-1:0]      r_fix;

    // Operand magnitudes for the issuing instruction
    always_comb begin
        in_sgn   = ~bus.i_op[0];
        in_neg_a = in_sgn & bus.i_data_a[LEN-1];
        in_neg_b = in_sgn & bus.i_data_b[LEN-1];
        abs_a    = in_neg_a ? -bus.i_data_a : bus.i_data_a;
        abs_b    = in_neg_b ? -bus.i_data_b : bus.i_data_b;
    end

    // One shift-add / shift-subtract step plus the final sign fix
    always_comb begin
        mul_sum  = {1'b0, acc[2*LEN-1:LEN]}
                 + (acc[0] ? {1'b0, opa} : '0);
        mul_nxt  = {mul_sum, acc[LEN-1:1]};
        div_sh   = {acc[2*LEN-1:LEN], acc[LEN-1]};
        div_diff = div_sh - {1'b0, opb};
        if (div_sh >= {1'b0, opb}) begin
            div_nxt = {div_diff[LEN-1:0], acc[LEN-2:0], 1'b1};
        end else begin
            div_nxt = {div_sh[LEN-1:0], acc[LEN-2:0], 1'b0};
        end
        prod_fix = (is_sgn & (sign_a ^ sign_b)) ? -acc : acc;
        q_fix    = (is_sgn & (sign_a ^ sign_b))
                 ? -acc[LEN-1:0] : acc[LEN-1:0];
        r_fix    = (is_sgn & sign_a)
                 ? -acc[2*LEN-1:LEN] : acc[2*LEN-1:LEN];
    end

    // Sequencer FSM, datapath and HI/LO registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            hi     <= '0;
            lo     <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            is_div <= 1'b0;
            is_sgn <= 1'b0;
            b_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.i_start && !bus.i_flush) begin
                        opa    <= abs_a;
                        opb    <= abs_b;
                        sign_a <= in_neg_a;
                        sign_b <= in_neg_b;
                        is_div <= bus.i_op[1];
                        is_sgn <= in_sgn;
                        b_zero <= (bus.i_data_b == '0);
                        acc    <= bus.i_op[1]
                                ? {{LEN{1'b0}}, abs_a}
                                : {{LEN{1'b0}}, abs_b};
                        cnt    <= NB_CNT'(LEN);
                        state  <= RUN;
                    end else if (!bus.i_start) begin
                        if (bus.i_mthi) hi <= bus.i_data_a;
                        if (bus.i_mtlo) lo <= bus.i_data_a;
                    end
                end
                RUN: begin
                    if (bus.i_flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= is_div ? div_nxt : mul_nxt;
                        cnt <= cnt - 1'b1;
                        if (cnt == NB_CNT'(1)) state <= FIX;
                    end
                end
                FIX: begin
                    if (bus.i_flush) begin
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            hi <= r_fix;
                            lo <= b_zero ? '1 : q_fix;
                        end else begin
                            hi <= prod_fix[2*LEN-1:LEN];
                            lo <= prod_fix[LEN-1:0];
                        end
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall covers the issue cycle through FIX; released in COMMIT
    always_comb begin
        unique case (state)
            IDLE:    bus.o_stall = bus.i_start & i_rst;
            RUN:     bus.o_stall = 1'b1;
            FIX:     bus.o_stall = 1'b1;
            COMMIT:  bus.o_stall = 1'b0;
        endcase
    end

    assign bus.o_busy = (state == RUN) || (state == FIX);
    assign bus.o_done = (state == COMMIT);
    assign bus.o_hi   = hi;
    assign bus.o_lo   = lo;

endmodule

// File: tb/tb_seg_execute_muldiv_ctrl.sv
// Randomized bench for the mul/div sequencer against a plain
// arithmetic reference model of MULT/MULTU/DIV/DIVU.
module tb_seg_execute_muldiv_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    seg_execute_muldiv_ctrl_if #(.LEN(32), .NB_OP(2)) bus ();

    seg_execute_muldiv_ctrl #(
        .LEN(32),
        .NB_CNT(6),
        .NB_OP(2)
    ) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic void model(input logic [1:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] hi,
                                  output logic [31:0] lo);
        logic [63:0] p;
        int sa;
        int sb;
        sa = a;
        sb = b;
        p  = '0;
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin
                p  = longint'(sa) * longint'(sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            2'd1: begin
                p  = {32'b0, a} * {32'b0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            2'd2: begin
                if (b == 0) begin
                    lo = '1;
                    hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = 0;
                end else begin
                    lo = sa / sb;
                    hi = sa % sb;
                end
            end
            default: begin
                if (b == 0) begin
                    lo = '1;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        int ns;
        int nb;
        int nd;
        ns = 0;
        nb = 0;
        nd = 0;
        @(negedge clk);
        bus.i_op     = op;
        bus.i_data_a = a;
        bus.i_data_b = b;
        bus.i_start  = 1'b1;
        #1;
        for (int k = 0; k < 100; k++) begin
            if (!bus.o_stall) break;
            ns++;
            if (bus.o_busy) nb++;
            if (bus.o_done) nd++;
            @(negedge clk);
            bus.i_data_a = $urandom;
            bus.i_data_b = $urandom;
            #1;
        end
        chk({tag, " stall_cycles"}, ns, 34);
        chk({tag, " busy_cycles"}, nb, 33);
        chk({tag, " early_done"}, nd, 0);
        chk({tag, " done"}, {31'b0, bus.o_done}, 1);
        chk({tag, " busy_commit"}, {31'b0, bus.o_busy}, 0);
        chk({tag, " hi"}, bus.o_hi, eh);
        chk({tag, " lo"}, bus.o_lo, el);
        bus.i_start = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, " done_pulse"}, {31'b0, bus.o_done}, 0);
        chk({tag, " stall_after"}, {31'b0, bus.o_stall}, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        logic [1:0]  op;
        int          nd;

        rst_n        = 1'b0;
        bus.i_start  = 1'b0;
        bus.i_op     = '0;
        bus.i_data_a = '0;
        bus.i_data_b = '0;
        bus.i_mthi   = 1'b0;
        bus.i_mtlo   = 1'b0;
        bus.i_flush  = 1'b0;
        #12;
        chk("rst stall", {31'b0, bus.o_stall}, 0);
        chk("rst busy", {31'b0, bus.o_busy}, 0);
        chk("rst done", {31'b0, bus.o_done}, 0);
        chk("rst hi", bus.o_hi, 0);
        chk("rst lo", bus.o_lo, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_m7x3", 2'd0, 32'hFFFF_FFF9, 32'h0000_0003,
               32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_m7d2", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_100d7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_5d0", 2'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0, 32'h8000_0000);

        @(negedge clk);
        bus.i_data_a = 32'h1234;
        bus.i_mthi   = 1'b1;
        @(negedge clk);
        bus.i_mthi   = 1'b0;
        bus.i_data_a = 32'h5678;
        bus.i_mtlo   = 1'b1;
        @(negedge clk);
        bus.i_mtlo   = 1'b0;
        #1;
        chk("mthi", bus.o_hi, 32'h1234);
        chk("mtlo", bus.o_lo, 32'h5678);

        @(negedge clk);
        bus.i_op     = 2'd0;
        bus.i_data_a = $urandom;
        bus.i_data_b = $urandom;
        bus.i_start  = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("flush busy_before", {31'b0, bus.o_busy}, 1);
        bus.i_start = 1'b0;
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        #1;
        chk("flush busy", {31'b0, bus.o_busy}, 0);
        chk("flush stall", {31'b0, bus.o_stall}, 0);
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.o_done) nd++;
            @(negedge clk);
            #1;
        end
        chk("flush no_done", nd, 0);
        chk("flush hi", bus.o_hi, 32'h1234);
        chk("flush lo", bus.o_lo, 32'h5678);

        @(negedge clk);
        bus.i_op     = 2'd3;
        bus.i_data_a = 32'd1000;
        bus.i_data_b = 32'd3;
        bus.i_start  = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst stall", {31'b0, bus.o_stall}, 0);
        chk("arst busy", {31'b0, bus.o_busy}, 0);
        chk("arst done", {31'b0, bus.o_done}, 0);
        chk("arst hi", bus.o_hi, 0);
        chk("arst lo", bus.o_lo, 0);
        @(negedge clk);
        bus.i_start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("arst idle", {31'b0, bus.o_busy}, 0);

        run_op("divu_post_rst", 2'd3, 32'd1000, 32'd3, 32'd1, 32'd333);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                3: a = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            model(op, a, b, eh, el);
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, eh, el);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
